// File: rtl/cnn_pkg.sv
// Shared CNN definitions: feature width, default image size,
// max-pool FSM states and a signed max helper.
package cnn_pkg;

  localparam int DATA_W     = 32;
  localparam int IMG_WIDTH  = 6;
  localparam int IMG_HEIGHT = 6;

  typedef enum logic [1:0] {
    POOL_IDLE,
    POOL_RUN,
    POOL_FLUSH,
    POOL_DONE
  } pool_state_t;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/max_pool_2x2_max2_signed.sv
// Combinational signed two-input maximum.
// Ports: a, b operands; y = larger of the two (two's complement).
module max2_signed
  import cnn_pkg::*;
#(
  parameter int W = cnn_pkg::DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = ($signed(a) > $signed(b)) ? a : b;

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 max pool with one row of partial maxima.
// Ports: clk, rst, start, in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_index, done.
module max_pool_2x2
  import cnn_pkg::*;
#(
  parameter int DATA_W    = cnn_pkg::DATA_W,
  parameter int IN_WIDTH  = IMG_WIDTH,
  parameter int IN_HEIGHT = IMG_HEIGHT,
  parameter int OUT_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [OUT_IDX_W-1:0] out_index,
  output logic                 done
);

  localparam int CW = $clog2(IN_WIDTH);
  localparam int RW = $clog2(IN_HEIGHT);
  localparam int NB = 1 << CW;
  localparam int NOUT = (IN_WIDTH / 2) * (IN_HEIGHT / 2);

  if (IN_WIDTH % 2 != 0) begin : g_bad_width
    $fatal(1, "max_pool_2x2: IN_WIDTH must be even");
  end
  if (IN_HEIGHT % 2 != 0) begin : g_bad_height
    $fatal(1, "max_pool_2x2: IN_HEIGHT must be even");
  end
  if ((NOUT - 1) >= (1 << OUT_IDX_W)) begin : g_bad_idx
    $fatal(1, "max_pool_2x2: OUT_IDX_W too narrow");
  end

  pool_state_t          state;
  logic [CW-1:0]        col;
  logic [CW-1:0]        bidx;
  logic [RW-1:0]        row;
  logic [OUT_IDX_W-1:0] cnt;
  logic [DATA_W-1:0]    pend;
  logic [DATA_W-1:0]    rowbuf [NB];
  logic [DATA_W-1:0]    pair_max;
  logic [DATA_W-1:0]    top_max;
  logic [DATA_W-1:0]    win_max;
  logic                 xfer;
  logic                 col_last;
  logic                 row_last;
  logic                 win_load;

  assign bidx = col >> 1;

  max2_signed #(.W(DATA_W)) u_pair (
    .a(pend), .b(in_data), .y(pair_max)
  );
  max2_signed #(.W(DATA_W)) u_top (
    .a(rowbuf[bidx]), .b(pend), .y(top_max)
  );
  max2_signed #(.W(DATA_W)) u_win (
    .a(top_max), .b(in_data), .y(win_max)
  );

  // Single-entry output register: accept when it is empty
  // or being popped this very cycle.
  assign in_ready = (state == POOL_RUN)
                  && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign col_last = (col == CW'(IN_WIDTH - 1));
  assign row_last = (row == RW'(IN_HEIGHT - 1));
  assign win_load = xfer && col[0] && row[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= POOL_IDLE;
      col       <= '0;
      row       <= '0;
      cnt       <= '0;
      pend      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      done      <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        rowbuf[i] <= '0;
      end
    end else begin
      done <= 1'b0;

      if (win_load) begin
        out_valid <= 1'b1;
        out_data  <= win_max;
        out_index <= cnt;
        cnt       <= cnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (xfer) begin
        if (!col[0]) begin
          pend <= in_data;
        end else if (!row[0]) begin
          rowbuf[bidx] <= pair_max;
        end
        if (col_last) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      unique case (state)
        POOL_IDLE: begin
          if (start) begin
            state <= POOL_RUN;
            col   <= '0;
            row   <= '0;
            cnt   <= '0;
          end
        end
        POOL_RUN: begin
          if (xfer && col_last && row_last) begin
            state <= POOL_FLUSH;
          end
        end
        POOL_FLUSH: begin
          if (!out_valid || out_ready) begin
            state <= POOL_DONE;
            done  <= 1'b1;
          end
        end
        POOL_DONE: begin
          state <= POOL_IDLE;
        end
        default: state <= POOL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed + randomized bench for max_pool_2x2 against a
// plain-arithmetic 2x2 max reference.
module tb_max_pool_2x2;

  localparam int W    = 6;
  localparam int H    = 6;
  localparam int NPIX = W * H;
  localparam int NOUT = (W / 2) * (H / 2);
  localparam int BUDGET = 2000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [31:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [31:0] out_data;
  logic [3:0]        out_index;
  logic              done;

  max_pool_2x2 dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pix [NPIX];
  int expv [NOUT];
  int got_d [$];
  int got_i [$];
  int done_cnt;
  int cyc = 0;
  bit acc;
  int first_acc, last_acc, stalls, p;
  bit timeout;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: max over each 2x2 window in raster output order.
  task automatic build_ref();
    for (int pr = 0; pr < H / 2; pr++) begin
      for (int pc = 0; pc < W / 2; pc++) begin
        int m;
        m = pix[(2 * pr) * W + 2 * pc];
        if (pix[(2 * pr) * W + 2 * pc + 1] > m) m = pix[(2 * pr) * W + 2 * pc + 1];
        if (pix[(2 * pr + 1) * W + 2 * pc] > m) m = pix[(2 * pr + 1) * W + 2 * pc];
        if (pix[(2 * pr + 1) * W + 2 * pc + 1] > m) m = pix[(2 * pr + 1) * W + 2 * pc + 1];
        expv[pr * (W / 2) + pc] = m;
      end
    end
  endtask

  task automatic ramp();
    for (int i = 0; i < NPIX; i++) pix[i] = i;
    build_ref();
  endtask

  task automatic cycle(input logic st, input logic iv,
                       input int d, input logic ordy);
    @(negedge clk);
    start = st;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_i.push_back(int'(out_index));
    end
    if (done) done_cnt++;
    cyc++;
  endtask

  task automatic run_frame(input int vpct, input int rpct,
                           input bit poke_start);
    int n;
    logic iv, ordy, st;
    got_d.delete();
    got_i.delete();
    done_cnt = 0;
    first_acc = -1;
    last_acc = -1;
    stalls = 0;
    p = 0;
    n = 0;
    cycle(1'b1, 1'b0, 0, 1'b1);
    while (done_cnt == 0 && n < BUDGET) begin
      iv = (p < NPIX) && ($urandom_range(99) < vpct);
      ordy = ($urandom_range(99) < rpct);
      st = poke_start && (p >= 10) && (p < 12);
      cycle(st, iv, (p < NPIX) ? pix[p] : 0, ordy);
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        p++;
      end
      if (iv && !acc) stalls++;
      n++;
    end
    timeout = (done_cnt == 0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_nres"}, got_d.size(), NOUT);
    for (int i = 0; i < NOUT && i < got_d.size(); i++) begin
      chk($sformatf("%s_idx%0d", tag, i), got_i[i], i);
      chk($sformatf("%s_dat%0d", tag, i), got_d[i], expv[i]);
    end
  endtask

  initial begin
    int unstable;
    bit seen;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_done", done, 0);

    // Ramp, continuous flow
    ramp();
    run_frame(100, 100, 1'b0);
    check_frame("ramp");
    chk("ramp_first", got_d.size() > 0 ? got_d[0] : -1, 7);
    chk("ramp_last", got_d.size() > 8 ? got_d[8] : -1, 35);
    chk("ramp_stalls", stalls, 0);
    chk("ramp_span", last_acc - first_acc + 1, NPIX);

    // Signed compare
    for (int i = 0; i < NPIX; i++) pix[i] = 0;
    pix[0] = -5;
    pix[1] = -2;
    pix[W] = -9;
    pix[W + 1] = -3;
    build_ref();
    run_frame(100, 100, 1'b0);
    check_frame("signed");
    chk("signed_win0", got_d.size() > 0 ? got_d[0] : 99, -2);

    // Back-pressure: consumer stalled from the start
    ramp();
    got_d.delete();
    got_i.delete();
    done_cnt = 0;
    p = 0;
    unstable = 0;
    seen = 0;
    cycle(1'b1, 1'b0, 0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      cycle(1'b0, p < NPIX, (p < NPIX) ? pix[p] : 0, 1'b0);
      if (acc) p++;
      if (out_valid) seen = 1;
      if (seen && !(out_valid && out_data == 7 && out_index == 0))
        unstable++;
    end
    chk("bp_accepted", p, 8);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 7);
    chk("bp_index", out_index, 0);
    chk("bp_unstable", unstable, 0);
    chk("bp_in_ready", in_ready, 0);
    begin
      int n = 0;
      while (done_cnt == 0 && n < BUDGET) begin
        cycle(1'b0, p < NPIX, (p < NPIX) ? pix[p] : 0, 1'b1);
        if (acc) p++;
        n++;
      end
      timeout = (done_cnt == 0);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 0, 1'b1);
    end
    check_frame("bp");

    // Random frame with random handshakes
    void'($urandom(32'h5eed_2024));
    for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom);
    build_ref();
    run_frame(60, 50, 1'b0);
    check_frame("rand");

    // Reset mid-frame, then a clean ramp
    ramp();
    done_cnt = 0;
    p = 0;
    cycle(1'b1, 1'b0, 0, 1'b1);
    while (p < 20 && cyc < 100000) begin
      cycle(1'b0, 1'b1, pix[p], 1'b1);
      if (acc) p++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_data", out_data, 0);
    got_d.delete();
    got_i.delete();
    done_cnt = 0;
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 0, 1'b1);
    chk("mid_rst_nout", got_d.size(), 0);
    chk("mid_rst_done", done_cnt, 0);
    run_frame(100, 100, 1'b0);
    check_frame("post_rst");

    // in_valid in IDLE, start pulsed during RUN
    p = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b1, 99, 1'b1);
      if (acc) p++;
    end
    chk("idle_accepts", p, 0);
    chk("idle_in_ready", in_ready, 0);
    ramp();
    run_frame(100, 100, 1'b1);
    check_frame("start_in_run");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
